// File: rtl/mul_rs_pkg.sv
// Shared types and constants for the multiply/divide reservation stations.
// Entry layout is fixed by XLEN and ROB_IDX_W below.
package mul_rs_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef struct packed {
        logic                 rdy;
        logic [ROB_IDX_W-1:0] tag;
        logic [XLEN-1:0]      value;
    } rs_operand_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
        logic [ROB_IDX_W-1:0] rob_idx;
        rs_operand_t          src1;
        rs_operand_t          src2;
    } rs_entry_t;

    // A waiting operand captures the broadcast value when its producer tag is on the CDB.
    function automatic rs_operand_t operand_wakeup(
        input rs_operand_t          op,
        input logic                 cdb_valid,
        input logic [ROB_IDX_W-1:0] cdb_tag,
        input logic [XLEN-1:0]      cdb_value
    );
        rs_operand_t res;
        res = op;
        if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
            res.rdy   = 1'b1;
            res.value = cdb_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: age_q[j][i] = 1 means entry j is older than entry i.
// Grants the oldest requesting entry, one-hot.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o
);

    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (free_i[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[i][j] = 1'b0;
                    age_d[j][i] = 1'b0;
                end
            end
        end
        // A new entry is younger than everything already present.
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_i[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[i][j] = 1'b0;
                    if (j != i) begin
                        age_d[j][i] = 1'b1;
                    end
                end
            end
        end
        if (flush_i) begin
            age_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
            logic [DEPTH-1:0] older;
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
                assign older[gj] = age_q[gj][gi];
            end
            assign grant_o[gi] = req_i[gi] & ~|(req_i & older);
        end
    endgenerate

endmodule

// File: rtl/mul_rs.sv
// Reservation station feeding the pipelined multiplier: holds MUL-class ops until
// both operands are known, snoops the CDB, and issues the oldest ready entry.
module mul_rs #(
    parameter int DEPTH     = 4,
    parameter int XLEN      = mul_rs_pkg::XLEN,
    parameter int ROB_IDX_W = mul_rs_pkg::ROB_IDX_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     dispatch_valid_i,
    output logic                     dispatch_ready_o,
    input  logic [XLEN-1:0]          dispatch_pc_i,
    input  logic [XLEN-1:0]          dispatch_inst_i,
    input  logic [ROB_IDX_W-1:0]     dispatch_rob_idx_i,
    input  logic                     rs1_ready_i,
    input  logic [XLEN-1:0]          rs1_value_i,
    input  logic [ROB_IDX_W-1:0]     rs1_tag_i,
    input  logic                     rs2_ready_i,
    input  logic [XLEN-1:0]          rs2_value_i,
    input  logic [ROB_IDX_W-1:0]     rs2_tag_i,
    input  logic                     cdb_valid_i,
    input  logic [ROB_IDX_W-1:0]     cdb_rob_idx_i,
    input  logic [XLEN-1:0]          cdb_value_i,
    output logic                     mul_request_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [XLEN-1:0]          inst_o,
    output logic [XLEN-1:0]          rs1_value_o,
    output logic [XLEN-1:0]          rs2_value_o,
    output logic [ROB_IDX_W-1:0]     rob_idx_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    import mul_rs_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    rs_entry_t entry_q [DEPTH];
    rs_entry_t entry_d [DEPTH];
    rs_entry_t new_entry;
    rs_entry_t sel_entry;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] cand_vec;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] grant_oh;
    logic [DEPTH-1:0] issue_oh;
    logic             dispatch_fire;
    logic             issue_fire;

    logic                 mul_request_q, mul_request_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      inst_q, inst_d;
    logic [XLEN-1:0]      rs1_value_q, rs1_value_d;
    logic [XLEN-1:0]      rs2_value_q, rs2_value_d;
    logic [ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;
    logic [OCC_W-1:0]     occupancy_q, occupancy_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign valid_vec[gi] = entry_q[gi].valid;
            assign cand_vec[gi]  = entry_q[gi].valid & entry_q[gi].src1.rdy & entry_q[gi].src2.rdy;
        end
    endgenerate

    // Readiness looks only at registered valids, so a same-cycle issue cannot free a slot.
    assign dispatch_ready_o = ~&valid_vec;
    assign dispatch_fire    = dispatch_valid_i & dispatch_ready_o & ~flush_i;
    assign issue_oh         = grant_oh & {DEPTH{~flush_i}};
    assign issue_fire       = |issue_oh;

    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_vec[i] && !found) begin
                alloc_oh[i] = dispatch_fire;
                found       = 1'b1;
            end
        end
    end

    rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .alloc_i (alloc_oh),
        .free_i  (issue_oh),
        .req_i   (cand_vec),
        .grant_o (grant_oh)
    );

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.pc      = dispatch_pc_i;
        new_entry.inst    = dispatch_inst_i;
        new_entry.rob_idx = dispatch_rob_idx_i;
        new_entry.src1    = operand_wakeup('{rdy: rs1_ready_i, tag: rs1_tag_i, value: rs1_value_i},
                                           cdb_valid_i, cdb_rob_idx_i, cdb_value_i);
        new_entry.src2    = operand_wakeup('{rdy: rs2_ready_i, tag: rs2_tag_i, value: rs2_value_i},
                                           cdb_valid_i, cdb_rob_idx_i, cdb_value_i);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid) begin
                entry_d[i].src1 = operand_wakeup(entry_q[i].src1, cdb_valid_i, cdb_rob_idx_i, cdb_value_i);
                entry_d[i].src2 = operand_wakeup(entry_q[i].src2, cdb_valid_i, cdb_rob_idx_i, cdb_value_i);
            end
            if (issue_oh[i]) begin
                entry_d[i].valid = 1'b0;
            end
            if (alloc_oh[i]) begin
                entry_d[i] = new_entry;
            end
            if (flush_i) begin
                entry_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_oh[i]) begin
                sel_entry = entry_q[i];
            end
        end
        mul_request_d = issue_fire;
        pc_d          = pc_q;
        inst_d        = inst_q;
        rs1_value_d   = rs1_value_q;
        rs2_value_d   = rs2_value_q;
        rob_idx_d     = rob_idx_q;
        if (issue_fire) begin
            pc_d        = sel_entry.pc;
            inst_d      = sel_entry.inst;
            rs1_value_d = sel_entry.src1.value;
            rs2_value_d = sel_entry.src2.value;
            rob_idx_d   = sel_entry.rob_idx;
        end
        occupancy_d = occupancy_q + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
        if (flush_i) begin
            occupancy_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            mul_request_q <= 1'b0;
            pc_q          <= '0;
            inst_q        <= '0;
            rs1_value_q   <= '0;
            rs2_value_q   <= '0;
            rob_idx_q     <= '0;
            occupancy_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            mul_request_q <= mul_request_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            rs1_value_q   <= rs1_value_d;
            rs2_value_q   <= rs2_value_d;
            rob_idx_q     <= rob_idx_d;
            occupancy_q   <= occupancy_d;
        end
    end

    assign mul_request_o = mul_request_q;
    assign pc_o          = pc_q;
    assign inst_o        = inst_q;
    assign rs1_value_o   = rs1_value_q;
    assign rs2_value_o   = rs2_value_q;
    assign rob_idx_o     = rob_idx_q;
    assign occupancy_o   = occupancy_q;

endmodule

// File: tb/tb_mul_rs.sv
// Directed self-checking bench for mul_rs: latency, wakeup, bypass, ordering,
// back-pressure, flush and asynchronous reset.
module tb_mul_rs;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        dispatch_valid_i;
    logic        dispatch_ready_o;
    logic [31:0] dispatch_pc_i;
    logic [31:0] dispatch_inst_i;
    logic [4:0]  dispatch_rob_idx_i;
    logic        rs1_ready_i, rs2_ready_i;
    logic [31:0] rs1_value_i, rs2_value_i;
    logic [4:0]  rs1_tag_i, rs2_tag_i;
    logic        cdb_valid_i;
    logic [4:0]  cdb_rob_idx_i;
    logic [31:0] cdb_value_i;
    logic        mul_request_o;
    logic [31:0] pc_o, inst_o, rs1_value_o, rs2_value_o;
    logic [4:0]  rob_idx_o;
    logic [2:0]  occupancy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mul_rs dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .flush_i            (flush_i),
        .dispatch_valid_i   (dispatch_valid_i),
        .dispatch_ready_o   (dispatch_ready_o),
        .dispatch_pc_i      (dispatch_pc_i),
        .dispatch_inst_i    (dispatch_inst_i),
        .dispatch_rob_idx_i (dispatch_rob_idx_i),
        .rs1_ready_i        (rs1_ready_i),
        .rs1_value_i        (rs1_value_i),
        .rs1_tag_i          (rs1_tag_i),
        .rs2_ready_i        (rs2_ready_i),
        .rs2_value_i        (rs2_value_i),
        .rs2_tag_i          (rs2_tag_i),
        .cdb_valid_i        (cdb_valid_i),
        .cdb_rob_idx_i      (cdb_rob_idx_i),
        .cdb_value_i        (cdb_value_i),
        .mul_request_o      (mul_request_o),
        .pc_o               (pc_o),
        .inst_o             (inst_o),
        .rs1_value_o        (rs1_value_o),
        .rs2_value_o        (rs2_value_o),
        .rob_idx_o          (rob_idx_o),
        .occupancy_o        (occupancy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dispatch_valid_i = 1'b0;
        cdb_valid_i      = 1'b0;
        flush_i          = 1'b0;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rob,
                            input logic r1rdy, input logic [31:0] r1v, input logic [4:0] r1t,
                            input logic r2rdy, input logic [31:0] r2v, input logic [4:0] r2t);
        dispatch_valid_i   = 1'b1;
        dispatch_pc_i      = pc;
        dispatch_inst_i    = inst;
        dispatch_rob_idx_i = rob;
        rs1_ready_i        = r1rdy;
        rs1_value_i        = r1v;
        rs1_tag_i          = r1t;
        rs2_ready_i        = r2rdy;
        rs2_value_i        = r2v;
        rs2_tag_i          = r2t;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] value);
        cdb_valid_i   = 1'b1;
        cdb_rob_idx_i = tag;
        cdb_value_i   = value;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b0;
        idle();
        dispatch(32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0);
        dispatch_valid_i = 1'b0;
        cdb_rob_idx_i    = 5'd0;
        cdb_value_i      = 32'h0;
        #1;
        chk("rst_req", {31'b0, mul_request_o}, 32'd0);
        chk("rst_occ", {29'b0, occupancy_o}, 32'd0);
        chk("rst_rob", {27'b0, rob_idx_o}, 32'd0);
        chk("rst_rs1", rs1_value_o, 32'd0);
        #21 reset_i = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, dispatch_ready_o}, 32'd1);

        // MULHU, both sources ready: request one cycle after the entry lands.
        dispatch(32'h0000_1000, 32'h0220_B1B3, 5'd3, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h2, 5'd0);
        tick();
        idle();
        chk("t1_occ_after_dispatch", {29'b0, occupancy_o}, 32'd1);
        chk("t1_no_early_req", {31'b0, mul_request_o}, 32'd0);
        tick();
        chk("t1_req", {31'b0, mul_request_o}, 32'd1);
        chk("t1_rob", {27'b0, rob_idx_o}, 32'd3);
        chk("t1_rs1", rs1_value_o, 32'hFFFF_FFFF);
        chk("t1_rs2", rs2_value_o, 32'h2);
        chk("t1_pc", pc_o, 32'h0000_1000);
        chk("t1_inst", inst_o, 32'h0220_B1B3);
        chk("t1_occ", {29'b0, occupancy_o}, 32'd0);
        tick();
        chk("t1_single_strobe", {31'b0, mul_request_o}, 32'd0);
        chk("t1_payload_hold", {27'b0, rob_idx_o}, 32'd3);

        // MUL with rs2 waiting on tag 7; an unrelated tag must not wake it.
        dispatch(32'h0000_2000, 32'h0220_8133, 5'd6, 1'b1, 32'h5, 5'd0, 1'b0, 32'h0, 5'd7);
        tick();
        idle();
        cdb(5'd8, 32'hDEAD);
        chk("t2_wait_c1", {31'b0, mul_request_o}, 32'd0);
        tick();
        idle();
        chk("t2_wait_c2", {31'b0, mul_request_o}, 32'd0);
        tick();
        cdb(5'd7, 32'h10);
        chk("t2_wait_c3", {31'b0, mul_request_o}, 32'd0);
        tick();
        idle();
        chk("t2_wake_edge", {31'b0, mul_request_o}, 32'd0);
        tick();
        chk("t2_req", {31'b0, mul_request_o}, 32'd1);
        chk("t2_rs2", rs2_value_o, 32'h10);
        chk("t2_rs1", rs1_value_o, 32'h5);
        chk("t2_rob", {27'b0, rob_idx_o}, 32'd6);
        tick();

        // Dispatch-cycle CDB bypass on rs1.
        dispatch(32'h0000_3000, 32'h0220_91B3, 5'd10, 1'b0, 32'h0, 5'd9, 1'b1, 32'h3, 5'd0);
        cdb(5'd9, 32'hABCD);
        tick();
        idle();
        chk("t3_no_early_req", {31'b0, mul_request_o}, 32'd0);
        tick();
        chk("t3_req", {31'b0, mul_request_o}, 32'd1);
        chk("t3_rs1", rs1_value_o, 32'hABCD);
        chk("t3_rob", {27'b0, rob_idx_o}, 32'd10);
        tick();

        // Fill all four entries waiting on tag 5, then release them together.
        for (int k = 1; k <= 4; k++) begin
            dispatch(32'h100 * k, 32'h0220_A1B3, 5'(k), 1'b0, 32'h0, 5'd5, 1'b1, 32'h100 * k, 5'd0);
            tick();
            chk($sformatf("t4_fill_occ%0d", k), {29'b0, occupancy_o}, k);
        end
        chk("t4_full_ready", {31'b0, dispatch_ready_o}, 32'd0);
        dispatch(32'hF00, 32'h0220_8133, 5'd15, 1'b1, 32'h1, 5'd0, 1'b1, 32'h1, 5'd0);
        tick();
        idle();
        chk("t4_ignored_occ", {29'b0, occupancy_o}, 32'd4);
        chk("t4_ignored_req", {31'b0, mul_request_o}, 32'd0);
        cdb(5'd5, 32'h55);
        tick();
        idle();
        chk("t4_wake_edge", {31'b0, mul_request_o}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t4_req%0d", k), {31'b0, mul_request_o}, 32'd1);
            chk($sformatf("t4_rob%0d", k), {27'b0, rob_idx_o}, k);
            chk($sformatf("t4_rs1_%0d", k), rs1_value_o, 32'h55);
            chk($sformatf("t4_rs2_%0d", k), rs2_value_o, 32'h100 * k);
            chk($sformatf("t4_occ%0d", k), {29'b0, occupancy_o}, 4 - k);
            chk($sformatf("t4_ready%0d", k), {31'b0, dispatch_ready_o}, 32'd1);
        end
        tick();
        chk("t4_drained", {31'b0, mul_request_o}, 32'd0);

        // Flush with three entries, one ready to issue at the flush edge.
        dispatch(32'h2000, 32'h0220_8133, 5'd20, 1'b0, 32'h0, 5'd21, 1'b1, 32'h7, 5'd0);
        tick();
        dispatch(32'h2004, 32'h0220_8133, 5'd22, 1'b1, 32'h8, 5'd0, 1'b0, 32'h0, 5'd23);
        tick();
        dispatch(32'h2008, 32'h0220_8133, 5'd24, 1'b1, 32'h9, 5'd0, 1'b1, 32'hA, 5'd0);
        tick();
        chk("t5_occ3", {29'b0, occupancy_o}, 32'd3);
        dispatch(32'h200C, 32'h0220_8133, 5'd25, 1'b1, 32'hB, 5'd0, 1'b1, 32'hC, 5'd0);
        flush_i = 1'b1;
        tick();
        idle();
        chk("t5_flush_req", {31'b0, mul_request_o}, 32'd0);
        chk("t5_flush_occ", {29'b0, occupancy_o}, 32'd0);
        chk("t5_flush_ready", {31'b0, dispatch_ready_o}, 32'd1);
        cdb(5'd21, 32'h21);
        tick();
        cdb(5'd23, 32'h23);
        chk("t5_after1", {31'b0, mul_request_o}, 32'd0);
        tick();
        idle();
        chk("t5_after2", {31'b0, mul_request_o}, 32'd0);
        tick();
        chk("t5_after3", {31'b0, mul_request_o}, 32'd0);
        tick();
        chk("t5_after4", {31'b0, mul_request_o}, 32'd0);
        chk("t5_after_occ", {29'b0, occupancy_o}, 32'd0);

        // Asynchronous reset while the request is high.
        dispatch(32'h3000, 32'h0220_B1B3, 5'd17, 1'b1, 32'h11, 5'd0, 1'b1, 32'h12, 5'd0);
        tick();
        idle();
        tick();
        chk("t6_req_before_rst", {31'b0, mul_request_o}, 32'd1);
        #2 reset_i = 1'b0;
        #1;
        chk("t6_rst_req", {31'b0, mul_request_o}, 32'd0);
        chk("t6_rst_rob", {27'b0, rob_idx_o}, 32'd0);
        chk("t6_rst_rs1", rs1_value_o, 32'd0);
        chk("t6_rst_occ", {29'b0, occupancy_o}, 32'd0);
        #3 reset_i = 1'b1;
        tick();
        chk("t6_ready", {31'b0, dispatch_ready_o}, 32'd1);
        chk("t6_occ", {29'b0, occupancy_o}, 32'd0);
        chk("t6_req", {31'b0, mul_request_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
